// File: rtl/cpu_run_sequencer.sv
// Launch sequencer for the lab3 core: queues start addresses and runs them one at a time.
// Each run is timed from the cycle after the start pulse up to done, with a timeout abort.
module cpu_run_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 15,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic                      req_valid_i,
  input  logic [ADDR_W-1:0]         req_addr_i,
  output logic                      req_ready_o,
  output logic                      cpu_start_o,
  output logic [ADDR_W-1:0]         cpu_start_addr_o,
  input  logic                      cpu_done_i,
  output logic                      res_valid_o,
  output logic [ADDR_W-1:0]         res_addr_o,
  output logic [CNT_W-1:0]          res_cycles_o,
  output logic                      res_timeout_o,
  output logic                      busy_o,
  output logic [$clog2(QDEPTH):0]   queue_count_o
);

  // state  | meaning
  // IDLE   | waiting for a queued request; pops the head when one is present
  // START  | one-cycle start pulse to the core, counter at 0
  // ARM    | done is still the previous run's level and is ignored, counter at 1
  // RUN    | waiting for done or the timeout compare
  // REPORT | one-cycle result strobe
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam int                 QAW       = $clog2(QDEPTH);
  localparam logic [QAW:0]       QDEPTH_C  = (QAW+1)'(QDEPTH);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_mem [QDEPTH];
  logic [QAW-1:0]      r_wr_ptr;
  logic [QAW-1:0]      r_rd_ptr;
  logic [QAW:0]        r_count;
  logic                r_ready_en;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_start_addr;
  logic [ADDR_W-1:0]   r_res_addr;
  logic [CNT_W-1:0]    r_res_cycles;
  logic                r_res_timeout;
  logic                w_push;
  logic                w_pop;
  logic                w_tc;

  // ready is held low until the first clock after reset release
  assign req_ready_o      = r_ready_en & (r_count != QDEPTH_C);
  assign w_push           = req_valid_i & req_ready_o;
  assign w_pop            = (r_state == S_IDLE) & (r_count != '0);
  assign w_tc             = (r_cnt == TIMEOUT_C);
  assign cpu_start_addr_o = r_start_addr;
  assign res_addr_o       = r_res_addr;
  assign res_cycles_o     = r_res_cycles;
  assign res_timeout_o    = r_res_timeout;
  assign queue_count_o    = r_count;

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_addr_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    cpu_start_o = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_next = S_START;
        end
      end
      S_START: begin
        cpu_start_o = 1'b1;
        w_next      = S_ARM;
      end
      S_ARM: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        if (cpu_done_i || w_tc) begin
          w_next = S_REPORT;
        end
      end
      S_REPORT: begin
        res_valid_o = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // r_cnt equals the number of cycles elapsed since the start pulse
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt         <= '0;
      r_start_addr  <= '0;
      r_res_addr    <= '0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_start_addr <= r_mem[r_rd_ptr];
            r_res_addr   <= r_mem[r_rd_ptr];
            r_cnt        <= '0;
          end
        end
        S_START: begin
          r_res_timeout <= 1'b0;
          r_cnt         <= r_cnt + 1'b1;
        end
        S_ARM: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_RUN: begin
          if (cpu_done_i) begin
            r_res_cycles <= r_cnt;
          end else if (w_tc) begin
            r_res_cycles  <= TIMEOUT_C;
            r_res_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
